// File: rtl/mchan_ext_pkg.sv
// Shared types and defaults for the external-interface transaction-ID logic.
package mchan_ext_pkg;

   localparam int EXT_TID_WIDTH_DEFAULT = 4;
   localparam int EXT_NB_TIDS_DEFAULT   = 16;

   typedef logic [EXT_TID_WIDTH_DEFAULT-1:0] ext_tid_t;

endpackage

// File: rtl/ext_tid_ff1.sv
// Find the first zero bit in vec_i, scanning upward from start_i and wrapping
// at N-1. idx_o is 0 and found_o is low when every bit is set.
module ext_tid_ff1 #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  vec_i,
   input  logic [IW-1:0] start_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   int pos;

   // Scan from the farthest offset down so the nearest free slot wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      pos     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(start_i) + k;
         if (pos >= N) pos = pos - N;
         if (!vec_i[pos]) begin
            idx_o   = IW'(pos);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ext_tid_gen.sv
// Transaction-ID pool for the external read/write interfaces.
// EXT_TID_RR_ALLOC_EN selects round-robin allocation; default is lowest-free-first.
module ext_tid_gen
   import mchan_ext_pkg::*;
#(
   parameter int EXT_TID_WIDTH = EXT_TID_WIDTH_DEFAULT,
   parameter int NB_TIDS       = EXT_NB_TIDS_DEFAULT,
   parameter int CNT_WIDTH     = $clog2(NB_TIDS + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     incr_i,
   output logic                     valid_tid_o,
   output logic [EXT_TID_WIDTH-1:0] tid_o,
   input  logic                     release_tid_i,
   input  logic [EXT_TID_WIDTH-1:0] tid_i,
   output logic [CNT_WIDTH-1:0]     outstanding_o,
   output logic                     idle_o,
   output logic                     err_o
);

   logic [NB_TIDS-1:0]       busy_q, busy_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic [EXT_TID_WIDTH-1:0] scan_start, free_idx;
   logic                     free_found;
   logic                     rel_busy, alloc, rel;

`ifdef EXT_TID_RR_ALLOC_EN
   logic [EXT_TID_WIDTH-1:0] ptr_q, ptr_d;
   assign scan_start = ptr_q;
`else
   assign scan_start = '0;
`endif

   ext_tid_ff1 #(
      .N  (NB_TIDS),
      .IW (EXT_TID_WIDTH)
   ) u_ff1 (
      .vec_i   (busy_q),
      .start_i (scan_start),
      .idx_o   (free_idx),
      .found_o (free_found)
   );

   assign valid_tid_o   = ~&busy_q;
   assign tid_o         = free_found ? free_idx : '0;
   assign outstanding_o = cnt_q;
   assign idle_o        = (cnt_q == '0);
   assign err_o         = err_q;

   always_comb begin
      rel_busy = 1'b0;
      if (int'(tid_i) < NB_TIDS) rel_busy = busy_q[tid_i];
   end

   assign alloc = incr_i & valid_tid_o;
   assign rel   = release_tid_i & rel_busy;

   // Allocation picks from pre-release state, so alloc and rel never hit the same bit.
   always_comb begin
      busy_d = busy_q;
      if (alloc) busy_d[tid_o] = 1'b1;
      if (rel)   busy_d[tid_i] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({alloc, rel})
         2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
         2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   assign err_d = err_q | (incr_i & ~valid_tid_o) | (release_tid_i & ~rel_busy);

`ifdef EXT_TID_RR_ALLOC_EN
   always_comb begin
      ptr_d = ptr_q;
      if (alloc) ptr_d = (int'(tid_o) == NB_TIDS - 1) ? '0 : tid_o + EXT_TID_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_ext_tid_gen.sv
// Scoreboard bench for ext_tid_gen: a reference pool model predicts each
// cycle's outputs, directed checks cover the pool boundary cases.
module tb_ext_tid_gen;
   import mchan_ext_pkg::*;

   localparam int W  = 4;
   localparam int NB = 16;
   localparam int CW = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          incr_i = 1'b0;
   logic          release_tid_i = 1'b0;
   ext_tid_t      tid_i = '0;
   logic          valid_tid_o;
   logic [W-1:0]  tid_o;
   logic [CW-1:0] outstanding_o;
   logic          idle_o;
   logic          err_o;

   always #5 clk_i = ~clk_i;

   ext_tid_gen #(
      .EXT_TID_WIDTH (W),
      .NB_TIDS       (NB),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .incr_i        (incr_i),
      .valid_tid_o   (valid_tid_o),
      .tid_o         (tid_o),
      .release_tid_i (release_tid_i),
      .tid_i         (tid_i),
      .outstanding_o (outstanding_o),
      .idle_o        (idle_o),
      .err_o         (err_o)
   );

   typedef struct packed {
      logic          v;
      logic [W-1:0]  t;
      logic [CW-1:0] c;
      logic          i;
      logic          e;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   bit m_busy[NB];
   int m_cnt;
   bit m_err;
   int m_ptr;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_valid();
      for (int k = 0; k < NB; k++) if (!m_busy[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_tid();
      int p;
      for (int k = 0; k < NB; k++) begin
         p = (m_ptr + k) % NB;
         if (!m_busy[p]) return p;
      end
      return 0;
   endfunction

   function automatic exp_t m_exp();
      exp_t e;
      e.v = m_valid();
      e.t = W'(m_tid());
      e.c = CW'(m_cnt);
      e.i = (m_cnt == 0);
      e.e = m_err;
      return e;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < NB; k++) m_busy[k] = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
      m_ptr = 0;
   endtask

   // Called #1 after a rising edge; drives one cycle and scores the result.
   task automatic step(input bit inc, input bit rel, input int tid);
      bit   v, a, r;
      int   t;
      exp_t e;
      v = m_valid();
      t = m_tid();
      a = inc && v;
      r = rel && (tid < NB) && m_busy[tid];
      incr_i        = inc;
      release_tid_i = rel;
      tid_i         = W'(tid);
      if ((inc && !v) || (rel && !r)) m_err = 1'b1;
      if (a) begin
         m_busy[t] = 1'b1;
`ifdef EXT_TID_RR_ALLOC_EN
         m_ptr = (t + 1) % NB;
`endif
      end
      if (r) m_busy[tid] = 1'b0;
      m_cnt = m_cnt + int'(a) - int'(r);
      sb_q.push_back(m_exp());
      @(posedge clk_i);
      #1;
      incr_i        = 1'b0;
      release_tid_i = 1'b0;
      e = sb_q.pop_front();
      check_val("sb_valid", valid_tid_o, e.v);
      check_val("sb_tid",   tid_o,       e.t);
      check_val("sb_cnt",   outstanding_o, e.c);
      check_val("sb_idle",  idle_o,      e.i);
      check_val("sb_err",   err_o,       e.e);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      m_reset();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check_val({pfx, "_valid"}, valid_tid_o, 1);
      check_val({pfx, "_tid"},   tid_o,       0);
      check_val({pfx, "_cnt"},   outstanding_o, 0);
      check_val({pfx, "_idle"},  idle_o,      1);
      check_val({pfx, "_err"},   err_o,       0);
   endtask

   initial begin
      int tid;

      m_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_vals("rst");
      rst_ni = 1'b1;

      // Fill the whole pool on consecutive cycles.
      for (int i = 0; i < NB; i++) begin
         check_val("fill_tid", tid_o, i);
         check_val("fill_valid", valid_tid_o, 1);
         step(1'b1, 1'b0, 0);
      end
      check_val("full_valid", valid_tid_o, 0);
      check_val("full_cnt",   outstanding_o, 16);
      check_val("full_idle",  idle_o, 0);

      // Free one slot in a full pool, then refill it.
      step(1'b0, 1'b1, 5);
      check_val("rel5_valid", valid_tid_o, 1);
      check_val("rel5_tid",   tid_o, 5);
      check_val("rel5_cnt",   outstanding_o, 15);
      step(1'b1, 1'b0, 0);
      check_val("refill_valid", valid_tid_o, 0);
      check_val("refill_cnt",   outstanding_o, 16);

      // Simultaneous allocate and release with three busy IDs.
      do_reset();
      repeat (3) step(1'b1, 1'b0, 0);
      check_val("simul_pre_tid", tid_o, 3);
      step(1'b1, 1'b1, 1);
      check_val("simul_cnt", outstanding_o, 3);
`ifndef EXT_TID_RR_ALLOC_EN
      check_val("simul_next_tid", tid_o, 1);
`endif

      // Protocol errors: release of a free ID, allocation from a full pool.
      check_val("err_pre", err_o, 0);
      step(1'b0, 1'b1, 7);
      check_val("err_rel_free", err_o, 1);
      check_val("err_rel_cnt",  outstanding_o, 3);
      for (int k = 0; k < NB && m_valid(); k++) step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      check_val("err_ovf_cnt",   outstanding_o, 16);
      check_val("err_ovf_valid", valid_tid_o, 0);
      repeat (3) step(1'b0, 1'b0, 0);
      check_val("err_sticky", err_o, 1);

      // Asynchronous reset with ten IDs in flight.
      do_reset();
      repeat (10) step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 12);
      check_val("pre_arst_err", err_o, 1);
      #1;
      rst_ni = 1'b0;
      #1;
      check_reset_vals("arst");
      m_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      check_val("post_arst_tid", tid_o, 0);
      step(1'b1, 1'b0, 0);
      check_val("post_arst_next", tid_o, 1);
      step(1'b0, 1'b1, 4);
      check_val("late_rel_err", err_o, 1);

`ifdef EXT_TID_RR_ALLOC_EN
      do_reset();
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      check_val("rr_tid", tid_o, 2);
      for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 0);
      check_val("rr_wrap", tid_o, 0);
`endif

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         tid = $urandom_range(0, NB - 1);
         if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < NB; k++) begin
               if (m_busy[(tid + k) % NB]) begin
                  tid = (tid + k) % NB;
                  break;
               end
            end
         end
         step(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1), tid);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ext_tid_gen.md
Name: ext_tid_gen

Overview:
- Transaction-ID allocator for the external read/write interfaces.
- Holds a pool of NB_TIDS IDs. It presents one free ID (tid_o, valid_tid_o) to the command side and marks it busy when the command is granted (incr_i).
- Returns an ID to the pool when the response side reports the last beat (release_tid_i, tid_i).
- Sits between the command queue and the ext rx/tx interfaces. It bounds the number of outstanding AXI bursts.

Parameters:
- EXT_TID_WIDTH, 4, width of the transaction ID.
- NB_TIDS, 16, number of IDs in the pool. Range 1..2**EXT_TID_WIDTH. Pool IDs are 0..NB_TIDS-1.
- CNT_WIDTH, $clog2(NB_TIDS+1), width of the outstanding counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- incr_i  in  1  allocate the ID currently on tid_o (the command-grant pulse)
- valid_tid_o  out  1  at least one ID is free
- tid_o  out  EXT_TID_WIDTH  ID to be used by the next command
- release_tid_i  in  1  free the ID on tid_i (last response beat)
- tid_i  in  EXT_TID_WIDTH  ID being released
- outstanding_o  out  CNT_WIDTH  number of busy IDs
- idle_o  out  1  no busy IDs
- err_o  out  1  sticky protocol error

Behaviour:
- State:
  - busy_q[NB_TIDS-1:0], one bit per ID.
  - cnt_q, the outstanding count.
  - err_q, the sticky error flag.
  - ptr_q, the round-robin pointer; exists only with the macro.
- Reset: busy_q=0, cnt_q=0, err_q=0, ptr_q=0.
  - Reset outputs: valid_tid_o=1, tid_o=0, outstanding_o=0, idle_o=1, err_o=0.
- valid_tid_o, tid_o, outstanding_o, idle_o and err_o depend only on registers. There is no combinational path from any input.
- valid_tid_o = ~&busy_q.
- tid_o = lowest index i with busy_q[i]==0. When none is free, tid_o=0 and valid_tid_o=0.
- Allocation:
  - Condition: incr_i && valid_tid_o. Effect: busy_q[tid_o] <= 1 at the next edge.
  - incr_i while valid_tid_o==0 is ignored and sets err_q.
- Release:
  - Condition: release_tid_i && tid_i<NB_TIDS && busy_q[tid_i]. Effect: busy_q[tid_i] <= 0 at the next edge.
  - Releasing an ID that is not busy or out of range changes no state and sets err_q.
- Simultaneous allocate and release in the same cycle:
  - Both apply and cnt_q is unchanged.
  - The allocated ID comes from pre-release busy_q, so a released ID is never reissued in the cycle it is freed.
  - Allocate and release may legally target the same ID only if that ID is busy and is also tid_o, which is impossible. That combination is therefore always a release of a different ID.
- Latency:
  - A freed ID is visible on tid_o/valid_tid_o one cycle after release_tid_i.
  - A newly allocated ID disappears from tid_o one cycle after incr_i.
- Counter:
  - cnt_q += alloc - rel, using only the valid alloc/rel conditions above.
  - It never exceeds NB_TIDS and never underflows.
- idle_o = (cnt_q==0).
- err_o = err_q. It is cleared only by reset.
- Reset mid-operation clears all IDs. In-flight responses arriving after reset are reported as errors on release.
- Throughput: one allocation and one release per cycle, sustained.

Optional Feature:
- Macro EXT_TID_RR_ALLOC_EN.
- Defined:
  - tid_o = first free ID at or after ptr_q, wrapping NB_TIDS-1 to 0.
  - On each successful allocation, ptr_q <= (tid_o+1) mod NB_TIDS.
  - This spreads ID reuse for AXI ordering and debug.
- Undefined: fixed lowest-index-first allocation and no ptr_q register. All other behaviour is identical.

Decomposition:
- Package mchan_ext_pkg holds:
  - typedef ext_tid_t, logic [EXT_TID_WIDTH-1:0];
  - constant EXT_NB_TIDS_DEFAULT.
- Sub-module ext_tid_ff1 is a parameterised find-first-zero.
  - Inputs: vector and start index.
  - Outputs: index and found flag.
  - It is used for both the fixed and the round-robin mode; the fixed mode passes start=0.

Test Plan:
- Reset, then 16 incr_i pulses on consecutive cycles (NB_TIDS=16):
  - tid_o steps 0,1,...,15;
  - valid_tid_o falls after the 16th pulse;
  - outstanding_o=16; idle_o=0.
- Pool full, release tid 5:
  - the next cycle shows valid_tid_o=1, tid_o=5, outstanding_o=15;
  - incr_i then restores full.
- With 3 busy IDs (0,1,2), incr_i and release(1) in the same cycle:
  - allocated ID is 3, not 1;
  - outstanding_o stays 3;
  - the next tid_o is 1.
- Release of tid 7 while it is free, and incr_i while the pool is full:
  - busy map and count are unchanged;
  - err_o=1 and stays 1 until rst_ni.
- With EXT_TID_RR_ALLOC_EN: allocate 0, 1, release 0, allocate:
  - the result is 2, not 0;
  - after wrap past 15, the first free ID from 0 is given.
- Assert rst_ni=0 with 10 IDs busy:
  - all outputs return to their reset values asynchronously;
  - the first incr_i after reset gets ID 0.
